sdram_init_monitor: RTL and testbench

Synthesizable checker sitting on the SDRAM command bus, on the device side of the controller's initialization sequencer. It decodes `{sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}` every cycle, enforces the JEDEC power-up order (wait, PRECHARGE-all, auto-refreshes, LOAD MODE REGISTER) and its spacing, and captures the programmed mode register. It reports completion or a sticky error code, for use in simulation benches and as an on-chip self-check in FPGA builds.

---
 rtl/sdram_init_monitor.sv | 236 +++++++++++++++++++++++
 tb/tb_sdram_init_monitor.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sdram_init_monitor.sv
// SDRAM power-up sequence monitor.
// Watches the device-side command bus and checks the JEDEC initialization
// order (wait, PRECHARGE-all, auto-refreshes, LOAD MODE REGISTER) and its
// command spacing. It captures the programmed mode register, and reports
// either completion or the first error seen (sticky until reset).
module sdram_init_monitor #(
  parameter int SDRAM_ADDR_WIDTH = 12,
  parameter int tINIT_CYCLE      = 10000,
  parameter int tRP_CYCLE        = 3,
  parameter int tRFC_CYCLE       = 7,
  parameter int tMRD_CYCLE       = 2,
  parameter int INIT_REF_CNT     = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sdram_cs_n,
  input  logic                        sdram_ras_n,
  input  logic                        sdram_cas_n,
  input  logic                        sdram_we_n,
  input  logic                        sdram_cke,
  input  logic [SDRAM_ADDR_WIDTH-1:0] sdram_addr,
  output logic                        init_ok,
  output logic                        init_err,
  output logic [2:0]                  err_code,
  output logic [SDRAM_ADDR_WIDTH-1:0] mode_reg,
  output logic [7:0]                  ref_count
);

  // Counter widths and saturation points.
  localparam int INIT_W   = $clog2(tINIT_CYCLE + 1);
  localparam int GAP_MAX0 = (tRP_CYCLE > tRFC_CYCLE) ? tRP_CYCLE : tRFC_CYCLE;
  localparam int GAP_MAX  = (GAP_MAX0 > tMRD_CYCLE) ? GAP_MAX0 : tMRD_CYCLE;
  localparam int GAP_W    = $clog2(GAP_MAX + 1);

  localparam logic [INIT_W-1:0] INIT_SAT = INIT_W'(tINIT_CYCLE);
  localparam logic [GAP_W-1:0]  GAP_SAT  = GAP_W'(GAP_MAX);
  localparam logic [GAP_W-1:0]  TRP_G    = GAP_W'(tRP_CYCLE);
  localparam logic [GAP_W-1:0]  TRFC_G   = GAP_W'(tRFC_CYCLE);
  localparam logic [GAP_W:0]    TMRD_X   = (GAP_W + 1)'(tMRD_CYCLE);
  localparam logic [7:0]        REF_MIN  = 8'((INIT_REF_CNT > 255) ? 255 : INIT_REF_CNT);

  // Error codes.
  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_EARLY  = 3'd1;
  localparam logic [2:0] ERR_ORDER  = 3'd2;
  localparam logic [2:0] ERR_TIMING = 3'd3;
  localparam logic [2:0] ERR_MODE   = 3'd4;

  // Command encodings {cs_n, ras_n, cas_n, we_n}.
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;

  typedef enum logic [5:0] {
    ST_PWR_WAIT = 6'b000001,
    ST_PRE_WAIT = 6'b000010,
    ST_REF      = 6'b000100,
    ST_LMR_WAIT = 6'b001000,
    ST_READY    = 6'b010000,
    ST_ERROR    = 6'b100000
  } state_e;

  // With a single-cycle tMRD, init_ok must already be high in the cycle after
  // the LMR, so the wait state is skipped.
  localparam state_e LMR_NEXT = (tMRD_CYCLE <= 1) ? ST_READY : ST_LMR_WAIT;

  // Mode register legality: CAS latency 2/3, burst length 1/2/4/8 or full
  // page (sequential only), and standard operating mode.
  function automatic logic mode_ok(input logic [8:0] a);
    logic cl_ok;
    logic bl_ok;
    cl_ok = (a[6:4] == 3'd2) || (a[6:4] == 3'd3);
    bl_ok = (a[2:0] <= 3'd3) || ((a[2:0] == 3'd7) && (a[3] == 1'b0));
    return cl_ok && bl_ok && (a[8:7] == 2'b00);
  endfunction

  state_e                      state_q, state_d;
  logic [INIT_W-1:0]           init_cnt_q, init_cnt_d;
  logic [GAP_W-1:0]            gap_q, gap_d;
  logic [2:0]                  err_code_q, err_code_d;
  logic [SDRAM_ADDR_WIDTH-1:0] mode_reg_q, mode_reg_d;
  logic [7:0]                  ref_count_q, ref_count_d;
  logic                        init_ok_q, init_ok_d;
  logic                        init_err_q, init_err_d;

  logic [3:0]       cmd_s;
  logic             is_idle_s;
  logic             is_pre_s;
  logic             is_ref_s;
  logic             is_lmr_s;
  logic [GAP_W:0]   gap_inc_s;

  // Command decode; a deasserted CKE makes the cycle an inhibit.
  always_comb begin
    cmd_s     = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
    is_idle_s = !sdram_cke || sdram_cs_n || (cmd_s == CMD_NOP);
    is_pre_s  = !is_idle_s && (cmd_s == CMD_PRE);
    is_ref_s  = !is_idle_s && (cmd_s == CMD_REF);
    is_lmr_s  = !is_idle_s && (cmd_s == CMD_LMR);
    gap_inc_s = {1'b0, gap_q} + (GAP_W + 1)'(1);
  end

  // Power-up wait counter and command spacing counter.
  always_comb begin
    init_cnt_d = init_cnt_q;
    gap_d      = gap_q;
    if (init_cnt_q < INIT_SAT) begin
      init_cnt_d = init_cnt_q + INIT_W'(1);
    end else begin
      init_cnt_d = init_cnt_q;
    end
    if (!is_idle_s) begin
      gap_d = GAP_W'(1);
    end else if (gap_q < GAP_SAT) begin
      gap_d = gap_q + GAP_W'(1);
    end else begin
      gap_d = gap_q;
    end
  end

  // Sequence FSM next-state, error capture and mode/refresh bookkeeping.
  always_comb begin
    state_d     = state_q;
    err_code_d  = err_code_q;
    mode_reg_d  = mode_reg_q;
    ref_count_d = ref_count_q;
    case (state_q)
      ST_PWR_WAIT: begin
        if (is_idle_s) begin
          state_d = ST_PWR_WAIT;
        end else if (init_cnt_q < INIT_SAT) begin
          state_d    = ST_ERROR;
          err_code_d = ERR_EARLY;
        end else if (is_pre_s && sdram_addr[10]) begin
          state_d = ST_PRE_WAIT;
        end else begin
          state_d    = ST_ERROR;
          err_code_d = ERR_ORDER;
        end
      end
      ST_PRE_WAIT: begin
        if (is_idle_s) begin
          state_d = ST_PRE_WAIT;
        end else if (is_ref_s && (gap_q >= TRP_G)) begin
          state_d     = ST_REF;
          ref_count_d = 8'd1;
        end else if (is_ref_s) begin
          state_d    = ST_ERROR;
          err_code_d = ERR_TIMING;
        end else begin
          state_d    = ST_ERROR;
          err_code_d = ERR_ORDER;
        end
      end
      ST_REF: begin
        if (is_idle_s) begin
          state_d = ST_REF;
        end else if (gap_q < TRFC_G) begin
          state_d    = ST_ERROR;
          err_code_d = ERR_TIMING;
        end else if (is_ref_s) begin
          if (ref_count_q != 8'hFF) begin
            ref_count_d = ref_count_q + 8'd1;
          end else begin
            ref_count_d = ref_count_q;
          end
        end else if (is_lmr_s && (ref_count_q >= REF_MIN)) begin
          if (mode_ok(sdram_addr[8:0])) begin
            state_d    = LMR_NEXT;
            mode_reg_d = sdram_addr;
          end else begin
            state_d    = ST_ERROR;
            err_code_d = ERR_MODE;
          end
        end else begin
          state_d    = ST_ERROR;
          err_code_d = ERR_ORDER;
        end
      end
      ST_LMR_WAIT: begin
        // Leave one cycle early so init_ok is visible exactly tMRD after LMR.
        if (!is_idle_s) begin
          state_d    = ST_ERROR;
          err_code_d = ERR_TIMING;
        end else if (gap_inc_s >= TMRD_X) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_LMR_WAIT;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d    = ST_PWR_WAIT;
        err_code_d = ERR_NONE;
      end
    endcase
    init_ok_d  = (state_d == ST_READY);
    init_err_d = (state_d == ST_ERROR);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_PWR_WAIT;
      init_cnt_q  <= '0;
      gap_q       <= GAP_SAT;
      err_code_q  <= ERR_NONE;
      mode_reg_q  <= '0;
      ref_count_q <= 8'd0;
      init_ok_q   <= 1'b0;
      init_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      gap_q       <= gap_d;
      err_code_q  <= err_code_d;
      mode_reg_q  <= mode_reg_d;
      ref_count_q <= ref_count_d;
      init_ok_q   <= init_ok_d;
      init_err_q  <= init_err_d;
    end
  end

  assign init_ok   = init_ok_q;
  assign init_err  = init_err_q;
  assign err_code  = err_code_q;
  assign mode_reg  = mode_reg_q;
  assign ref_count = ref_count_q;

endmodule

// File: tb/tb_sdram_init_monitor.sv
// Table-driven bench for sdram_init_monitor (default parameters).
// Each record holds the bus inputs, how many clock edges to hold them, and
// the outputs expected just after the last of those edges.
module tb_sdram_init_monitor;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] REF = 4'b0001;
  localparam logic [3:0] LMR = 4'b0000;
  localparam logic [3:0] INH = 4'b1000;

  typedef struct {
    int         run;
    logic       rst;
    logic       cke;
    logic [3:0] cmd;
    logic [11:0] addr;
    int         cyc;
    logic       ok;
    logic       err;
    logic [2:0] code;
    logic [11:0] mode;
    logic [7:0] refc;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic        sdram_cke;
  logic [11:0] sdram_addr;
  logic        init_ok;
  logic        init_err;
  logic [2:0]  err_code;
  logic [11:0] mode_reg;
  logic [7:0]  ref_count;

  vec_t vq[$];
  int   nvec;
  int   nbad;
  int   cur_run;

  sdram_init_monitor dut (
    .clk        (clk),
    .reset      (reset),
    .sdram_cs_n (sdram_cs_n),
    .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n),
    .sdram_we_n (sdram_we_n),
    .sdram_cke  (sdram_cke),
    .sdram_addr (sdram_addr),
    .init_ok    (init_ok),
    .init_err   (init_err),
    .err_code   (err_code),
    .mode_reg   (mode_reg),
    .ref_count  (ref_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic add(input logic rst, input logic cke, input logic [3:0] cmd,
                     input logic [11:0] addr, input int cyc,
                     input logic ok, input logic err, input logic [2:0] code,
                     input logic [11:0] mode, input logic [7:0] refc);
    vec_t v;
    v.run = cur_run; v.rst = rst; v.cke = cke; v.cmd = cmd; v.addr = addr;
    v.cyc = cyc; v.ok = ok; v.err = err; v.code = code; v.mode = mode;
    v.refc = refc;
    vq.push_back(v);
  endtask

  // Reset for two edges, then 10000 idle cycles (cycles 0..9999).
  task automatic add_init();
    cur_run = cur_run + 1;
    add(1'b1, 1'b1, NOP, 12'h000, 2,     1'b0, 1'b0, 3'd0, 12'h000, 8'd0);
    add(1'b0, 1'b1, NOP, 12'h000, 10000, 1'b0, 1'b0, 3'd0, 12'h000, 8'd0);
  endtask

  // PRE-all at cycle 10000, first REF at exactly tRP, then n-1 REFs at tRFC.
  task automatic add_refs(input int n);
    add(1'b0, 1'b1, PRE, 12'h400, 1, 1'b0, 1'b0, 3'd0, 12'h000, 8'd0);
    add(1'b0, 1'b1, NOP, 12'h000, 2, 1'b0, 1'b0, 3'd0, 12'h000, 8'd0);
    add(1'b0, 1'b1, REF, 12'h000, 1, 1'b0, 1'b0, 3'd0, 12'h000, 8'd1);
    for (int k = 2; k <= n; k++) begin
      add(1'b0, 1'b1, NOP, 12'h000, 6, 1'b0, 1'b0, 3'd0, 12'h000, 8'(k - 1));
      add(1'b0, 1'b1, REF, 12'h000, 1, 1'b0, 1'b0, 3'd0, 12'h000, 8'(k));
    end
  endtask

  // Compare all outputs against an expectation and report a mismatch.
  task automatic chk(input string tag, input logic ok, input logic err,
                     input logic [2:0] code, input logic [11:0] mode,
                     input logic [7:0] refc);
    nvec = nvec + 1;
    if ({init_ok, init_err, err_code, mode_reg, ref_count} !==
        {ok, err, code, mode, refc}) begin
      nbad = nbad + 1;
      $display("FAIL %s: got ok=%b err=%b code=%0d mode=%h ref=%0d, want ok=%b err=%b code=%0d mode=%h ref=%0d",
               tag, init_ok, init_err, err_code, mode_reg, ref_count,
               ok, err, code, mode, refc);
    end
  endtask

  initial begin
    vec_t v;
    nvec = 0;
    nbad = 0;
    cur_run = 0;

    // Run 1: reset after 4 REFs, then full legal sequence; reset in READY.
    add_init();
    add_refs(4);
    add(1'b1, 1'b1, NOP, 12'h000, 1, 1'b0, 1'b0, 3'd0, 12'h000, 8'd0);
    add_init();
    add_refs(8);
    add(1'b0, 1'b1, NOP, 12'h000, 6, 1'b0, 1'b0, 3'd0, 12'h000, 8'd8);
    add(1'b0, 1'b1, LMR, 12'h032, 1, 1'b0, 1'b0, 3'd0, 12'h032, 8'd8);
    add(1'b0, 1'b1, NOP, 12'h000, 1, 1'b1, 1'b0, 3'd0, 12'h032, 8'd8);
    add(1'b0, 1'b1, ACT, 12'h000, 1, 1'b1, 1'b0, 3'd0, 12'h032, 8'd8);
    add(1'b0, 1'b1, REF, 12'h000, 1, 1'b1, 1'b0, 3'd0, 12'h032, 8'd8);
    add(1'b1, 1'b1, NOP, 12'h000, 1, 1'b0, 1'b0, 3'd0, 12'h000, 8'd0);

    // Run 2: CKE-low LMR and INH during the wait are ignored; PRE at 9999 is EARLY.
    cur_run = cur_run + 1;
    add(1'b1, 1'b1, NOP, 12'h000, 2,    1'b0, 1'b0, 3'd0, 12'h000, 8'd0);
    add(1'b0, 1'b0, LMR, 12'h032, 5,    1'b0, 1'b0, 3'd0, 12'h000, 8'd0);
    add(1'b0, 1'b1, INH, 12'h400, 3,    1'b0, 1'b0, 3'd0, 12'h000, 8'd0);
    add(1'b0, 1'b1, NOP, 12'h000, 9991, 1'b0, 1'b0, 3'd0, 12'h000, 8'd0);
    add(1'b0, 1'b1, PRE, 12'h400, 1,    1'b0, 1'b1, 3'd1, 12'h000, 8'd0);
    add(1'b0, 1'b1, NOP, 12'h000, 3,    1'b0, 1'b1, 3'd1, 12'h000, 8'd0);

    // Run 3: REF 6 cycles after previous REF -> TIMING; later error ignored.
    add_init();
    add_refs(1);
    add(1'b0, 1'b1, NOP, 12'h000, 5, 1'b0, 1'b0, 3'd0, 12'h000, 8'd1);
    add(1'b0, 1'b1, REF, 12'h000, 1, 1'b0, 1'b1, 3'd3, 12'h000, 8'd1);
    add(1'b0, 1'b1, NOP, 12'h000, 2, 1'b0, 1'b1, 3'd3, 12'h000, 8'd1);
    add(1'b0, 1'b1, PRE, 12'h000, 1, 1'b0, 1'b1, 3'd3, 12'h000, 8'd1);

    // Run 4: ACT at L+1 during LMR wait -> TIMING, init_ok never rises.
    add_init();
    add_refs(8);
    add(1'b0, 1'b1, NOP, 12'h000, 6, 1'b0, 1'b0, 3'd0, 12'h000, 8'd8);
    add(1'b0, 1'b1, LMR, 12'h032, 1, 1'b0, 1'b0, 3'd0, 12'h032, 8'd8);
    add(1'b0, 1'b1, ACT, 12'h000, 1, 1'b0, 1'b1, 3'd3, 12'h032, 8'd8);
    add(1'b0, 1'b1, NOP, 12'h000, 4, 1'b0, 1'b1, 3'd3, 12'h032, 8'd8);

    // Run 5: LMR after only 7 REFs -> ORDER.
    add_init();
    add_refs(7);
    add(1'b0, 1'b1, NOP, 12'h000, 6, 1'b0, 1'b0, 3'd0, 12'h000, 8'd7);
    add(1'b0, 1'b1, LMR, 12'h032, 1, 1'b0, 1'b1, 3'd2, 12'h000, 8'd7);

    // Run 6: PRE without addr[10] -> ORDER.
    add_init();
    add(1'b0, 1'b1, PRE, 12'h000, 1, 1'b0, 1'b1, 3'd2, 12'h000, 8'd0);

    // Run 7: LMR with CAS latency 1 -> MODE, mode_reg not captured.
    add_init();
    add_refs(8);
    add(1'b0, 1'b1, NOP, 12'h000, 6, 1'b0, 1'b0, 3'd0, 12'h000, 8'd8);
    add(1'b0, 1'b1, LMR, 12'h012, 1, 1'b0, 1'b1, 3'd4, 12'h000, 8'd8);
    add(1'b0, 1'b1, NOP, 12'h000, 2, 1'b0, 1'b1, 3'd4, 12'h000, 8'd8);

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      reset     = v.rst;
      sdram_cke = v.cke;
      {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = v.cmd;
      sdram_addr = v.addr;
      repeat (v.cyc) @(posedge clk);
      #1;
      chk($sformatf("run%0d vec%0d", v.run, i), v.ok, v.err, v.code, v.mode, v.refc);
    end

    reset     = 1'b1;
    sdram_cke = 1'b1;
    {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = NOP;
    sdram_addr = 12'h000;
    @(posedge clk);
    #1;
    chk("reset-state from ERROR", 1'b0, 1'b0, 3'd0, 12'h000, 8'd0);

    reset = 1'b0;
    repeat (10000) @(posedge clk);
    #1;
    {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = PRE;
    sdram_addr = 12'h400;
    @(posedge clk);
    #1;
    chk("expired-wait PRE accepted", 1'b0, 1'b0, 3'd0, 12'h000, 8'd0);
    {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = NOP;
    sdram_addr = 12'h000;
    repeat (3) @(posedge clk);
    #1;
    chk("expired-wait no late error", 1'b0, 1'b0, 3'd0, 12'h000, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
